// File: rtl/spart_rx_fifo.sv
// SPART serial receiver: 8N1 deserialiser with mid-bit sampling feeding a small FWFT FIFO.
// Optional stop-bit checking is enabled by defining SPART_RX_FRAME_CHK_EN.
module spart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic                     rd_en,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  output logic                     framing_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             rx_meta_q, rx_s_q, rx_dly_q;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             fall_s, push_s;

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             overrun_q;
  logic             full_s, pop_s, wr_s, drop_s;

  assign fall_s = rx_dly_q & ~rx_s_q;

`ifdef SPART_RX_FRAME_CHK_EN
  logic stop_bad_s;
  logic framing_err_q;
`endif

  // Line synchroniser and edge-detect delay stage (idle level is high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_dly_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_dly_q  <= rx_s_q;
    end
  end

  // Frame FSM: half-divisor wait to start-bit centre, then full-divisor steps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    push_s  = 1'b0;
`ifdef SPART_RX_FRAME_CHK_EN
    stop_bad_s = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          div_d   = baud_div;
          cnt_d   = (baud_div >> 1) - DIV_W'(1);
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == {DIV_W{1'b0}}) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = div_q - DIV_W'(1);
            bit_d   = 3'd0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == {DIV_W{1'b0}}) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = div_q - DIV_W'(1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == {DIV_W{1'b0}}) begin
          state_d = S_IDLE;
`ifdef SPART_RX_FRAME_CHK_EN
          if (rx_s_q) begin
            push_s = 1'b1;
          end else begin
            stop_bad_s = 1'b1;
          end
`else
          push_s = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO control: a pop in the same cycle frees the slot for a push into a full FIFO.
  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    pop_s   = rd_en & (count_q != {CW{1'b0}});
    wr_s    = push_s & (~full_s | pop_s);
    drop_s  = push_s & full_s & ~pop_s;
    count_d = count_q;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State, datapath and FIFO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {DIV_W{1'b0}};
      div_q     <= {DIV_W{1'b0}};
      bit_q     <= 3'd0;
      shreg_q   <= 8'h00;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      count_q   <= count_d;
      overrun_q <= drop_s;
      if (wr_s) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

`ifdef SPART_RX_FRAME_CHK_EN
  // Framing error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      framing_err_q <= 1'b0;
    end else begin
      framing_err_q <= stop_bad_s;
    end
  end
  assign framing_err = framing_err_q;
`else
  assign framing_err = 1'b0;
`endif

  assign rx_data    = mem_q[rd_ptr_q];
  assign rx_valid   = (count_q != {CW{1'b0}});
  assign fifo_count = count_q;
  assign overrun    = overrun_q;

endmodule
